// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared encodings and reset constants for the multi-channel
// waveform generator.
//   - wave encodings used by cfg_wave and the per-channel active/shadow config
//   - sequencer state enum (exported on wave_gen_multi.state_o)
//   - reset values of the channel configuration
package wave_gen_pkg;

   localparam logic [1:0] WAVE_SINE  = 2'd0;
   localparam logic [1:0] WAVE_PULSE = 2'd1;
   localparam logic [1:0] WAVE_TRI   = 2'd2;
   localparam logic [1:0] WAVE_SAW   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wg_state_t;

   // Reset configuration. The reset max is "all ones" at the instance's
   // sample width, so it is written as '1 where it is used.
   localparam logic [1:0] RST_WAVE = WAVE_SINE;
   localparam int         RST_STEP = 0;
   localparam int         RST_MIN  = 0;
   localparam logic [6:0] RST_DUTY = 7'd50;

   localparam logic [6:0] DUTY_MAX = 7'd100;

endpackage

// File: rtl/sine_lut.sv
// sine_lut: registered quarter-wave sine table, one cycle of latency.
//   CLOCK, RESET : clock, asynchronous active-high reset
//   phase_i[9:0] : top 10 phase bits (quadrant in [9:8], position in [7:0])
//   u_o[DW-1:0]  : unit-level sine sample, centred on 2^(DW-1)
// The 256 quarter-wave entries e[k] = round((2^(DW-1)-1)*sin(pi(2k+1)/1024))
// are elaborated from an integer Taylor series, so the table is pure
// constants after elaboration.
module sine_lut #(
   parameter int DW = 12
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic [9:0]    phase_i,
   output logic [DW-1:0] u_o
);

   // pi in Q30 fixed point
   localparam longint PI_Q30 = 64'sd3373259426;

   function automatic logic [DW-2:0] entry(input int k);
      longint x;
      longint x2;
      longint term;
      longint s;
      longint e;
      x    = (PI_Q30 * longint'(2 * k + 1)) / 64'sd1024;
      x2   = (x * x) >>> 30;
      term = x;
      s    = x;
      // sin(x) = x - x^3/3! + x^5/5! - ... ; seven correction terms are
      // far below one LSB for x <= pi/2.
      for (int n = 1; n <= 7; n++) begin
         term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
         s    = s + term;
      end
      e = (longint'((1 << (DW - 1)) - 1) * s + (longint'(1) <<< 29)) >>> 30;
      return e[DW-2:0];
   endfunction

   logic [DW-2:0] rom [256];

   for (genvar g = 0; g < 256; g++) begin : g_rom
      localparam logic [DW-2:0] ENTRY = entry(g);
      assign rom[g] = ENTRY;
   end

   logic [7:0]    idx;
   logic [DW-2:0] e_sel;
   logic [DW-1:0] u_d;
   logic [DW-1:0] u_q;

   // Odd quadrants run the quarter wave backwards; the second half of the
   // period sits below mid-scale.
   always_comb begin
      idx   = phase_i[8] ? ~phase_i[7:0] : phase_i[7:0];
      e_sel = rom[idx];
      if (phase_i[9]) begin
         u_d = {1'b0, {(DW-1){1'b1}}} - {1'b0, e_sel};
      end else begin
         u_d = {1'b1, {(DW-1){1'b0}}} + {1'b0, e_sel};
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         u_q <= '0;
      end else begin
         u_q <= u_d;
      end
   end

   assign u_o = u_q;

endmodule

// File: rtl/wave_gen_multi.sv
// wave_gen_multi: N-channel phase-accumulator waveform generator sharing one
// engine across channels, sequenced once per sample tick.
//   CLOCK, RESET    : clock, asynchronous active-high reset
//   tick            : one-cycle sample strobe; honoured only in IDLE
//   enable[NCH]     : per-channel run (0 = phase held at 0, output = min)
//   cfg_valid/ready : config write handshake (see below)
//   cfg_ch/wave/step/min/max/duty : config payload
//   cfg_err         : one-cycle pulse after a rejected write
//   sample          : lane c at [c*DW +: DW], all lanes load together
//   sample_valid    : one-cycle pulse when sample updates
//   overrun         : sticky, set by a tick arriving outside IDLE
//   state_o         : sequencer state, for observation
// Requires PW >= DW+1 and PW >= 10.
module wave_gen_multi
   import wave_gen_pkg::*;
#(
   parameter int NCH = 2,
   parameter int DW  = 12,
   parameter int PW  = 24,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              tick,
   input  logic [NCH-1:0]    enable,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CHW-1:0]    cfg_ch,
   input  logic [1:0]        cfg_wave,
   input  logic [PW-1:0]     cfg_step,
   input  logic [DW-1:0]     cfg_min,
   input  logic [DW-1:0]     cfg_max,
   input  logic [6:0]        cfg_duty,
   output logic              cfg_err,
   output logic [NCH*DW-1:0] sample,
   output logic              sample_valid,
   output logic              overrun,
   output wg_state_t         state_o
);

   // Handshake: a config beat transfers on a rising edge where
   // cfg_valid && cfg_ready. cfg_ready is high only while IDLE and does not
   // depend on cfg_valid. A transferred beat is either stored in the shadow
   // register or rejected with cfg_err one cycle later.

   wg_state_t      state_q, state_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic           drain_q, drain_d;

   logic [PW-1:0]  phase_q    [NCH];
   logic [1:0]     act_wave_q [NCH];
   logic [PW-1:0]  act_step_q [NCH];
   logic [DW-1:0]  act_min_q  [NCH];
   logic [DW-1:0]  act_max_q  [NCH];
   logic [6:0]     act_duty_q [NCH];
   logic [1:0]     sh_wave_q  [NCH];
   logic [PW-1:0]  sh_step_q  [NCH];
   logic [DW-1:0]  sh_min_q   [NCH];
   logic [DW-1:0]  sh_max_q   [NCH];
   logic [6:0]     sh_duty_q  [NCH];

   logic [DW-1:0]  stage_q    [NCH];
   logic [NCH*DW-1:0] sample_q;
   logic           sample_valid_q;
   logic           cfg_err_q;
   logic           overrun_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      drain_d = drain_q;
      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_ISSUE;
               ch_d    = '0;
            end
         end
         ST_ISSUE: begin
            if (ch_q == CHW'(NCH - 1)) begin
               state_d = ST_DRAIN;
               ch_d    = '0;
               drain_d = 1'b0;
            end else begin
               ch_d = ch_q + CHW'(1);
            end
         end
         ST_DRAIN: begin
            // Two cycles let the last channel clear the multiply and
            // staging stages.
            drain_d = 1'b1;
            if (drain_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         drain_q <= drain_d;
      end
   end

   // ------------------------------------------------------- config write
   logic cfg_acc;
   logic cfg_bad;
   logic cfg_wr;

   assign cfg_ready = (state_q == ST_IDLE);
   assign cfg_acc   = cfg_valid && cfg_ready;
   assign cfg_bad   = (cfg_min > cfg_max) || (cfg_duty > DUTY_MAX) ||
                      (int'(cfg_ch) >= NCH);
   assign cfg_wr    = cfg_acc && !cfg_bad;

   // ---------------------------------------- stage 0: read + unit level
   logic [PW-1:0] p_cur;
   logic [1:0]    w_cur;
   logic [6:0]    duty_cur;
   logic [DW-1:0] tri_t;
   logic          pulse_hi;
   logic [DW-1:0] u_raw;
   logic [PW:0]   sum_w;
   logic          issue;

   assign issue = (state_q == ST_ISSUE);
   assign sum_w = {1'b0, phase_q[ch_q]} + {1'b0, act_step_q[ch_q]};

   always_comb begin
      p_cur    = phase_q[ch_q];
      w_cur    = act_wave_q[ch_q];
      duty_cur = act_duty_q[ch_q];
      tri_t    = p_cur[PW-2 -: DW];
      // Integer form of "phase fraction < duty percent".
      pulse_hi = (17'(p_cur[PW-1 -: 10]) * 17'd100) < (17'(duty_cur) * 17'd1024);
      u_raw    = '0;
      case (w_cur)
         WAVE_SAW:   u_raw = p_cur[PW-1 -: DW];
         WAVE_TRI:   u_raw = p_cur[PW-1] ? ~tri_t : tri_t;
         WAVE_PULSE: u_raw = pulse_hi ? '1 : '0;
         default:    u_raw = '0;
      endcase
   end

   logic [DW-1:0] lut_u;

   sine_lut #(.DW(DW)) u_sine_lut (
      .CLOCK   (CLOCK),
      .RESET   (RESET),
      .phase_i (p_cur[PW-1 -: 10]),
      .u_o     (lut_u)
   );

   logic           s0_valid_q;
   logic [CHW-1:0] s0_ch_q;
   logic [1:0]     s0_wave_q;
   logic [DW-1:0]  s0_u_q;
   logic [DW-1:0]  s0_min_q;
   logic [DW-1:0]  s0_max_q;
   logic           s0_en_q;

   // ------------------------------------------- stage 1: scale to range
   logic [DW-1:0] u_sel;
   logic [DW:0]   span;
   logic [DW-1:0] out_d;

   always_comb begin
      u_sel = (s0_wave_q == WAVE_SINE) ? lut_u : s0_u_q;
      if (!s0_en_q) begin
         u_sel = '0;
      end
      span  = {1'b0, s0_max_q} - {1'b0, s0_min_q} + {{DW{1'b0}}, 1'b1};
      out_d = s0_min_q +
              DW'(((2*DW+1)'(span) * (2*DW+1)'(u_sel)) >> DW);
   end

   logic           s1_valid_q;
   logic [CHW-1:0] s1_ch_q;
   logic [DW-1:0]  s1_out_q;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         s0_valid_q <= 1'b0;
         s0_ch_q    <= '0;
         s0_wave_q  <= RST_WAVE;
         s0_u_q     <= '0;
         s0_min_q   <= '0;
         s0_max_q   <= '0;
         s0_en_q    <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_ch_q    <= '0;
         s1_out_q   <= '0;
      end else begin
         s0_valid_q <= issue;
         s0_ch_q    <= ch_q;
         s0_wave_q  <= w_cur;
         s0_u_q     <= u_raw;
         s0_min_q   <= act_min_q[ch_q];
         s0_max_q   <= act_max_q[ch_q];
         s0_en_q    <= enable[ch_q];
         s1_valid_q <= s0_valid_q;
         s1_ch_q    <= s0_ch_q;
         s1_out_q   <= out_d;
      end
   end

   // ---------------------------- phase, config, staging and output regs
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int c = 0; c < NCH; c++) begin
            phase_q[c]    <= '0;
            act_wave_q[c] <= RST_WAVE;
            act_step_q[c] <= PW'(RST_STEP);
            act_min_q[c]  <= DW'(RST_MIN);
            act_max_q[c]  <= '1;
            act_duty_q[c] <= RST_DUTY;
            sh_wave_q[c]  <= RST_WAVE;
            sh_step_q[c]  <= PW'(RST_STEP);
            sh_min_q[c]   <= DW'(RST_MIN);
            sh_max_q[c]   <= '1;
            sh_duty_q[c]  <= RST_DUTY;
            stage_q[c]    <= '0;
         end
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         cfg_err_q      <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (issue && (ch_q == CHW'(c))) begin
               if (enable[c]) begin
                  phase_q[c] <= sum_w[PW-1:0];
                  // Phase wrap is the only glitch-free point to switch
                  // to the pending configuration.
                  if (sum_w[PW]) begin
                     act_wave_q[c] <= sh_wave_q[c];
                     act_step_q[c] <= sh_step_q[c];
                     act_min_q[c]  <= sh_min_q[c];
                     act_max_q[c]  <= sh_max_q[c];
                     act_duty_q[c] <= sh_duty_q[c];
                  end
               end else begin
                  phase_q[c] <= '0;
               end
            end
            if (cfg_wr && (cfg_ch == CHW'(c))) begin
               sh_wave_q[c] <= cfg_wave;
               sh_step_q[c] <= cfg_step;
               sh_min_q[c]  <= cfg_min;
               sh_max_q[c]  <= cfg_max;
               sh_duty_q[c] <= cfg_duty;
               // A stopped channel has no wrap to wait for.
               if (!enable[c]) begin
                  act_wave_q[c] <= cfg_wave;
                  act_step_q[c] <= cfg_step;
                  act_min_q[c]  <= cfg_min;
                  act_max_q[c]  <= cfg_max;
                  act_duty_q[c] <= cfg_duty;
               end
            end
            if (s1_valid_q && (s1_ch_q == CHW'(c))) begin
               stage_q[c] <= s1_out_q;
            end
            if (state_q == ST_DONE) begin
               sample_q[c*DW +: DW] <= stage_q[c];
            end
         end
         sample_valid_q <= (state_q == ST_DONE);
         cfg_err_q      <= cfg_acc && cfg_bad;
         if (tick && (state_q != ST_IDLE)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign cfg_err      = cfg_err_q;
   assign overrun      = overrun_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_wave_gen_multi.sv
// tb_wave_gen_multi: self-checking bench for wave_gen_multi with three
// channels, so that an out-of-range channel number is representable.
module tb_wave_gen_multi;
   import wave_gen_pkg::*;

   localparam int NCH = 3;
   localparam int DW  = 12;
   localparam int PW  = 24;
   localparam int SW  = NCH * DW;
   localparam int LAT = NCH + 3;
   localparam real PI = 3.14159265358979323846;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic          tick;
   logic [NCH-1:0] enable;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [1:0]    cfg_wave;
   logic [PW-1:0] cfg_step;
   logic [DW-1:0] cfg_min;
   logic [DW-1:0] cfg_max;
   logic [6:0]    cfg_duty;
   logic          cfg_err;
   logic [SW-1:0] sample;
   logic          sample_valid;
   logic          overrun;
   wg_state_t     state_o;

   int total = 0;
   int bad   = 0;

   logic [SW-1:0] exp_q[$];

   wave_gen_multi #(.NCH(NCH), .DW(DW), .PW(PW)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .tick         (tick),
      .enable       (enable),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_ch       (cfg_ch),
      .cfg_wave     (cfg_wave),
      .cfg_step     (cfg_step),
      .cfg_min      (cfg_min),
      .cfg_max      (cfg_max),
      .cfg_duty     (cfg_duty),
      .cfg_err      (cfg_err),
      .sample       (sample),
      .sample_valid (sample_valid),
      .overrun      (overrun),
      .state_o      (state_o)
   );

   // ------------------------------------------------ clock / reset
   always #5 CLOCK = ~CLOCK;

   // ------------------------------------------------ reference model
   typedef struct {
      int wave;
      int step;
      int mn;
      int mx;
      int duty;
   } mcfg_t;

   mcfg_t m_act [NCH];
   mcfg_t m_sh  [NCH];
   int    m_phase [NCH];

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_act[c] = '{wave: 0, step: 0, mn: 0, mx: 4095, duty: 50};
         m_sh[c]  = m_act[c];
         m_phase[c] = 0;
      end
   endfunction

   // Level for one channel straight from the waveform definitions.
   function automatic int ref_level(mcfg_t k, int ph);
      int  u;
      int  p10;
      int  t;
      int  e;
      real s;
      p10 = ph >> 14;
      case (k.wave)
         3: u = ph >> 12;
         2: begin
            t = (ph >> 11) & 4095;
            u = (ph >= 'h800000) ? 4095 - t : t;
         end
         1: u = (p10 * 100 < k.duty * 1024) ? 4095 : 0;
         default: begin
            s = $sin(2.0 * PI * (real'(p10) + 0.5) / 1024.0);
            e = $rtoi(2047.0 * ((s < 0.0) ? -s : s) + 0.5);
            u = (s >= 0.0) ? 2048 + e : 2047 - e;
         end
      endcase
      return k.mn + (((k.mx - k.mn + 1) * u) >> 12);
   endfunction

   function automatic logic [SW-1:0] model_tick();
      logic [SW-1:0] v;
      int np;
      v = '0;
      for (int c = 0; c < NCH; c++) begin
         if (enable[c]) begin
            v[c*DW +: DW] = DW'(ref_level(m_act[c], m_phase[c]));
            np = m_phase[c] + m_act[c].step;
            if (np >= (1 << PW)) begin
               np = np - (1 << PW);
               m_act[c] = m_sh[c];
            end
            m_phase[c] = np;
         end else begin
            v[c*DW +: DW] = DW'(m_act[c].mn);
            m_phase[c] = 0;
         end
      end
      return v;
   endfunction

   // Returns 1 when the write is expected to be rejected.
   function automatic bit model_write(int ch, mcfg_t k);
      if (k.mn > k.mx || k.duty > 100 || ch >= NCH) return 1'b1;
      m_sh[ch] = k;
      if (!enable[ch]) m_act[ch] = k;
      return 1'b0;
   endfunction

   // ------------------------------------------------ drivers
   task automatic apply_reset();
      @(negedge CLOCK);
      RESET = 1'b1;
      tick = 1'b0;
      cfg_valid = 1'b0;
      repeat (2) @(negedge CLOCK);
      RESET = 1'b0;
      model_reset();
      exp_q.delete();
      @(negedge CLOCK);
   endtask

   // One tick, then wait (bounded) for sample_valid. lat = -1 on timeout.
   task automatic do_tick(output logic [SW-1:0] got, output int lat);
      @(negedge CLOCK);
      tick = 1'b1;
      @(negedge CLOCK);
      tick = 1'b0;
      lat = -1;
      got = 'x;
      for (int n = 1; n <= 40; n++) begin
         @(negedge CLOCK);
         if (sample_valid) begin
            lat = n;
            got = sample;
            break;
         end
      end
   endtask

   // One write beat; err = cfg_err the cycle after, err2 = the cycle after that.
   task automatic cfg_write(input int ch, input mcfg_t k,
                            output logic err, output logic err2, output bit exp_bad);
      int w;
      @(negedge CLOCK);
      cfg_ch = 2'(ch);
      cfg_wave = 2'(k.wave);
      cfg_step = PW'(k.step);
      cfg_min = DW'(k.mn);
      cfg_max = DW'(k.mx);
      cfg_duty = 7'(k.duty);
      cfg_valid = 1'b1;
      w = 0;
      while (!cfg_ready && w < 40) begin
         @(negedge CLOCK);
         w++;
      end
      exp_bad = model_write(ch, k);
      @(negedge CLOCK);
      cfg_valid = 1'b0;
      err = cfg_err;
      @(negedge CLOCK);
      err2 = cfg_err;
   endtask

   // ------------------------------------------------ tests
   task automatic test_reset();
      apply_reset();
      total++; if (sample !== '0) begin bad++; $display("FAIL reset_sample got=%h exp=0", sample); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
      total++; if (state_o !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
   endtask

   task automatic test_saw();
      logic [SW-1:0] got, exp;
      logic e1, e2;
      bit eb;
      int lat;
      enable = '0;
      cfg_write(0, '{wave: 3, step: 'h200000, mn: 0, mx: 4095, duty: 50}, e1, e2, eb);
      total++; if (e1 !== eb || e2 !== 1'b0) begin bad++; $display("FAIL saw_cfg err=%b,%b exp=%b,0", e1, e2, eb); end
      enable = 3'b001;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(model_tick());
         do_tick(got, lat);
         exp = exp_q.pop_front();
         total++; if (got !== exp || lat != LAT) begin bad++; $display("FAIL saw_%0d got=%h lat=%0d exp=%h lat=%0d", i, got, lat, exp, LAT); end
         total++; if (got[11:0] !== 12'((i % 8) * 512)) begin bad++; $display("FAIL saw_lane0_%0d got=%0d exp=%0d", i, got[11:0], (i % 8) * 512); end
      end
      @(negedge CLOCK);
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL saw_valid_pulse got=%b exp=0", sample_valid); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge CLOCK);
      tick = 1'b1;
      @(negedge CLOCK);
      tick = 1'b0;
      @(negedge CLOCK);
      total++; if (state_o !== ST_ISSUE) begin bad++; $display("FAIL mid_in_issue got=%0d exp=1", state_o); end
      RESET = 1'b1;
      #1;
      total++; if (sample !== '0) begin bad++; $display("FAIL mid_sample got=%h exp=0", sample); end
      total++; if (cfg_ready !== 1'b1 || overrun !== 1'b0 || sample_valid !== 1'b0)
         begin bad++; $display("FAIL mid_flags got=%b%b%b exp=100", cfg_ready, overrun, sample_valid); end
      @(negedge CLOCK);
      RESET = 1'b0;
      model_reset();
      seen = 1'b0;
      repeat (LAT + 6) begin
         @(negedge CLOCK);
         if (sample_valid) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_valid got=1 exp=0"); end
   endtask

   task automatic test_pulse();
      logic [SW-1:0] got, exp;
      logic e1, e2;
      bit eb;
      int lat;
      int lv;
      int duties[3] = '{25, 0, 100};
      int counts[3] = '{20, 4, 4};
      for (int d = 0; d < 3; d++) begin
         enable = '0;
         cfg_write(1, '{wave: 1, step: 'h100000, mn: 100, mx: 200, duty: duties[d]}, e1, e2, eb);
         total++; if (e1 !== eb) begin bad++; $display("FAIL pulse_cfg_%0d err=%b exp=%b", d, e1, eb); end
         // Disabled tick restarts the phase at 0.
         exp_q.push_back(model_tick());
         do_tick(got, lat);
         exp = exp_q.pop_front();
         total++; if (got !== exp) begin bad++; $display("FAIL pulse_off_%0d got=%h exp=%h", d, got, exp); end
         enable = 3'b010;
         for (int i = 0; i < counts[d]; i++) begin
            exp_q.push_back(model_tick());
            do_tick(got, lat);
            exp = exp_q.pop_front();
            if (d == 0) lv = ((i % 16) < 4) ? 200 : 100;
            else if (d == 1) lv = 100;
            else lv = 200;
            total++; if (got !== exp || got[23:12] !== 12'(lv))
               begin bad++; $display("FAIL pulse_d%0d_%0d got=%h lane1=%0d exp=%h lane1=%0d", duties[d], i, got, got[23:12], exp, lv); end
         end
      end
   endtask

   task automatic test_cfg_change();
      logic [SW-1:0] got, exp;
      logic e1, e2;
      bit eb;
      int lat;
      int want[7] = '{0, 1024, 2048, 3072, 0, 2048, 0};
      enable = '0;
      exp_q.push_back(model_tick());
      do_tick(got, lat);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL chg_clear got=%h exp=%h", got, exp); end
      cfg_write(0, '{wave: 3, step: 'h400000, mn: 0, mx: 4095, duty: 50}, e1, e2, eb);
      enable = 3'b001;
      for (int i = 0; i < 7; i++) begin
         if (i == 1) begin
            cfg_write(0, '{wave: 3, step: 'h800000, mn: 0, mx: 4095, duty: 50}, e1, e2, eb);
            total++; if (e1 !== 1'b0) begin bad++; $display("FAIL chg_cfg err=%b exp=0", e1); end
         end
         exp_q.push_back(model_tick());
         do_tick(got, lat);
         exp = exp_q.pop_front();
         total++; if (got !== exp || got[11:0] !== 12'(want[i]))
            begin bad++; $display("FAIL chg_%0d got=%h lane0=%0d exp=%h lane0=%0d", i, got, got[11:0], exp, want[i]); end
      end
   endtask

   task automatic test_reject();
      logic [SW-1:0] got, exp;
      logic e1, e2;
      bit eb;
      int lat;
      cfg_write(0, '{wave: 3, step: 'h100000, mn: 300, mx: 200, duty: 50}, e1, e2, eb);
      total++; if (e1 !== 1'b1 || e2 !== 1'b0) begin bad++; $display("FAIL rej_minmax err=%b,%b exp=1,0", e1, e2); end
      cfg_write(0, '{wave: 1, step: 'h100000, mn: 0, mx: 200, duty: 101}, e1, e2, eb);
      total++; if (e1 !== 1'b1 || e2 !== 1'b0) begin bad++; $display("FAIL rej_duty err=%b,%b exp=1,0", e1, e2); end
      cfg_write(NCH, '{wave: 2, step: 'h100000, mn: 0, mx: 200, duty: 50}, e1, e2, eb);
      total++; if (e1 !== 1'b1 || e2 !== 1'b0) begin bad++; $display("FAIL rej_chan err=%b,%b exp=1,0", e1, e2); end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model_tick());
         do_tick(got, lat);
         exp = exp_q.pop_front();
         total++; if (got !== exp) begin bad++; $display("FAIL rej_seq_%0d got=%h exp=%h", i, got, exp); end
      end
      // Sine at phase 0, full range.
      enable = '0;
      exp_q.push_back(model_tick());
      do_tick(got, lat);
      void'(exp_q.pop_front());
      cfg_write(0, '{wave: 0, step: 'h010000, mn: 0, mx: 4095, duty: 50}, e1, e2, eb);
      enable = 3'b001;
      exp_q.push_back(model_tick());
      do_tick(got, lat);
      exp = exp_q.pop_front();
      total++; if (got[11:0] !== 12'd2054 || got !== exp)
         begin bad++; $display("FAIL sine_zero got=%0d exp=2054 (vec %h vs %h)", got[11:0], got, exp); end
   endtask

   task automatic test_random();
      logic [SW-1:0] got, exp;
      logic e1, e2;
      bit eb;
      int lat;
      mcfg_t k;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) enable = NCH'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            k.wave = $urandom_range(0, 3);
            k.step = $urandom_range(0, 'hFFFFFF);
            k.mn   = $urandom_range(0, 4095);
            k.mx   = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0 && k.mn > k.mx) begin
               lat = k.mn; k.mn = k.mx; k.mx = lat;
            end
            k.duty = $urandom_range(0, 110);
            cfg_write($urandom_range(0, 3), k, e1, e2, eb);
            total++; if (e1 !== eb || e2 !== 1'b0) begin bad++; $display("FAIL rnd_cfg_%0d err=%b,%b exp=%b,0", i, e1, e2, eb); end
         end
         exp_q.push_back(model_tick());
         do_tick(got, lat);
         exp = exp_q.pop_front();
         total++; if (got !== exp || lat != LAT) begin bad++; $display("FAIL rnd_%0d got=%h lat=%0d exp=%h lat=%0d", i, got, lat, exp, LAT); end
      end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rnd_no_overrun got=%b exp=0", overrun); end
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] got, exp;
      int nvalid;
      int lat;
      exp = model_tick();
      got = 'x;
      nvalid = 0;
      @(negedge CLOCK);
      tick = 1'b1;
      @(negedge CLOCK);
      tick = 1'b0;
      @(negedge CLOCK);
      tick = 1'b1;
      @(negedge CLOCK);
      tick = 1'b0;
      repeat (20) begin
         @(negedge CLOCK);
         if (sample_valid) begin
            nvalid++;
            got = sample;
         end
      end
      total++; if (nvalid != 1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", nvalid); end
      total++; if (got !== exp) begin bad++; $display("FAIL b2b_sample got=%h exp=%h", got, exp); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
      exp_q.push_back(model_tick());
      do_tick(got, lat);
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL b2b_after got=%h exp=%h", got, exp); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL b2b_sticky got=%b exp=1", overrun); end
      apply_reset();
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_reset got=%b exp=0", overrun); end
   endtask

   // ------------------------------------------------ sequence + report
   initial begin
      RESET = 1'b1;
      tick = 1'b0;
      enable = '0;
      cfg_valid = 1'b0;
      cfg_ch = '0;
      cfg_wave = '0;
      cfg_step = '0;
      cfg_min = '0;
      cfg_max = '0;
      cfg_duty = '0;
      model_reset();
      test_reset();
      test_saw();
      test_reset_mid();
      test_pulse();
      test_cfg_change();
      test_reject();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
